// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 registered-feedback burst master: a single client line request becomes one fixed-length
// incrementing (linear or wrapping) burst. Define WB_BURST_TIMEOUT_EN to enable the ack watchdog.
module wb_b3_burst_master #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int burst_len      = 4,
  parameter int wrap           = 1,
  parameter int timeout_cycles = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [aw-1:0]     req_adr_i,
  input  logic [dw-1:0]     wr_dat_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [dw-1:0]     rd_dat_o,
  output logic              rd_valid_o,
  output logic              done_o,
  output logic              err_o,
  output logic [aw-1:0]     wbm_adr_o,
  output logic [dw-1:0]     wbm_dat_o,
  output logic [dw/8-1:0]   wbm_sel_o,
  output logic              wbm_we_o,
  output logic [2:0]        wbm_cti_o,
  output logic [1:0]        wbm_bte_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i,
  input  logic [dw-1:0]     wbm_dat_i
);

  localparam int              LB        = $clog2(burst_len);
  localparam int              BW        = 5;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(burst_len - 1);
  localparam logic [1:0]      BTE_BURST = (wrap == 0)       ? 2'b00 :
                                          (burst_len == 4)  ? 2'b01 :
                                          (burst_len == 8)  ? 2'b10 : 2'b11;

  typedef enum logic { S_IDLE, S_BURST } state_e;

  state_e          state_q, state_d;
  logic [aw-1:0]   adr_q, adr_d, adr_inc;
  logic            we_q, we_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            in_burst, last_beat, bus_fault, ack_ok, abort, tmo_hit;
  logic            unused_adr_lsb;

  assign unused_adr_lsb = ^req_adr_i[1:0];

  assign in_burst  = (state_q == S_BURST);
  assign last_beat = (beat_q == LAST_BEAT);
  assign bus_fault = wbm_err_i | wbm_rty_i;
  // A coincident err/rty overrides ack: the beat is neither counted nor delivered.
  assign ack_ok    = in_burst & wbm_ack_i & ~bus_fault;
  assign abort     = in_burst & (bus_fault | tmo_hit);

  assign wbm_stb_o = in_burst & (~we_q | wr_valid_i);

`ifdef WB_BURST_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (!in_burst || wbm_ack_i) begin
      tmo_d = '0;
    end else if (wbm_stb_o) begin
      tmo_hit = (tmo_q == TW'(timeout_cycles - 1));
      tmo_d   = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  localparam int unused_timeout_cycles = timeout_cycles;

  assign tmo_hit = 1'b0;
`endif

  // Wrap mode only advances the low word-index bits, so the burst stays inside its aligned block.
  always_comb begin
    adr_inc = adr_q + aw'(4);
    if (wrap != 0) begin
      adr_inc            = adr_q;
      adr_inc[LB+1:2]    = adr_q[LB+1:2] + LB'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_BURST;
          adr_d   = {req_adr_i[aw-1:2], 2'b00};
          we_d    = req_we_i;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (ack_ok) begin
          if (last_beat) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
            adr_d  = adr_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = ~in_burst;
  assign wr_ready_o  = ack_ok & we_q;
  assign rd_valid_o  = ack_ok & ~we_q;
  assign rd_dat_o    = wbm_dat_i;
  assign done_o      = done_q;
  assign err_o       = err_q;

  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = wr_dat_i;
  assign wbm_sel_o   = '1;
  assign wbm_we_o    = we_q;
  assign wbm_cti_o   = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
  assign wbm_bte_o   = in_burst ? BTE_BURST : 2'b00;
  assign wbm_cyc_o   = in_burst;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Bench for wb_b3_burst_master: instance A is a 4-beat wrap master, instance B an 8-beat linear master.
module tb_wb_b3_burst_master;

  localparam logic [31:0] PAT = 32'hC0DE_0000;

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;
  beat_t sb[$];

  // Instance A signals
  logic        req_valid_a, req_ready_a, req_we_a, wr_valid_a, wr_ready_a, rd_valid_a, done_a, err_o_a;
  logic [31:0] req_adr_a, wr_dat_a, rd_dat_a, adr_a, dat_o_a, dat_i_a;
  logic [3:0]  sel_a;
  logic        we_a, cyc_a, stb_a, ack_a, err_a, rty_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;
  logic        hang_a, err_now_a;

  // Instance B signals
  logic        req_valid_b, req_ready_b, req_we_b, wr_valid_b, wr_ready_b, rd_valid_b, done_b, err_o_b;
  logic [31:0] req_adr_b, wr_dat_b, rd_dat_b, adr_b, dat_o_b, dat_i_b;
  logic [3:0]  sel_b;
  logic        we_b, cyc_b, stb_b, ack_b, err_b, rty_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;

  // Zero-wait slaves: ack in the same cycle as stb, read data derived from the address.
  assign ack_a   = stb_a & ~hang_a & ~err_now_a;
  assign err_a   = stb_a & err_now_a;
  assign rty_a   = 1'b0;
  assign dat_i_a = adr_a ^ PAT;
  assign ack_b   = stb_b;
  assign err_b   = 1'b0;
  assign rty_b   = 1'b0;
  assign dat_i_b = adr_b ^ PAT;

  wb_b3_burst_master #(
    .dw(32), .aw(32), .burst_len(4), .wrap(1), .timeout_cycles(8)
  ) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_we_i(req_we_a), .req_adr_i(req_adr_a),
    .wr_dat_i(wr_dat_a), .wr_valid_i(wr_valid_a), .wr_ready_o(wr_ready_a),
    .rd_dat_o(rd_dat_a), .rd_valid_o(rd_valid_a), .done_o(done_a), .err_o(err_o_a),
    .wbm_adr_o(adr_a), .wbm_dat_o(dat_o_a), .wbm_sel_o(sel_a), .wbm_we_o(we_a),
    .wbm_cti_o(cti_a), .wbm_bte_o(bte_a), .wbm_cyc_o(cyc_a), .wbm_stb_o(stb_a),
    .wbm_ack_i(ack_a), .wbm_err_i(err_a), .wbm_rty_i(rty_a), .wbm_dat_i(dat_i_a)
  );

  wb_b3_burst_master #(
    .dw(32), .aw(32), .burst_len(8), .wrap(0), .timeout_cycles(8)
  ) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_we_i(req_we_b), .req_adr_i(req_adr_b),
    .wr_dat_i(wr_dat_b), .wr_valid_i(wr_valid_b), .wr_ready_o(wr_ready_b),
    .rd_dat_o(rd_dat_b), .rd_valid_o(rd_valid_b), .done_o(done_b), .err_o(err_o_b),
    .wbm_adr_o(adr_b), .wbm_dat_o(dat_o_b), .wbm_sel_o(sel_b), .wbm_we_o(we_b),
    .wbm_cti_o(cti_b), .wbm_bte_o(bte_b), .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b),
    .wbm_ack_i(ack_b), .wbm_err_i(err_b), .wbm_rty_i(rty_b), .wbm_dat_i(dat_i_b)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_a); end
    checks++;
    if ({cyc_a, stb_a, we_a} !== 3'b000) begin errors++; $display("FAIL reset_cyc_stb_we: got %b want 000", {cyc_a, stb_a, we_a}); end
    checks++;
    if ({done_a, err_o_a} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b want 00", {done_a, err_o_a}); end
    checks++;
    if ({adr_a, cti_a, bte_a} !== 37'h0) begin errors++; $display("FAIL reset_adr_cti_bte: got %h/%b/%b want 0/000/00", adr_a, cti_a, bte_a); end
    checks++;
    if ({cyc_b, bte_b, sel_a} !== 7'b000_1111) begin errors++; $display("FAIL reset_b_sel: got %b want 0001111", {cyc_b, bte_b, sel_a}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap_read;
    logic [31:0] exp_adr [4];
    beat_t e;
    int n_rd = 0;
    bit fin = 1'b0;
    exp_adr = '{32'h1C, 32'h10, 32'h14, 32'h18};
    sb.delete();
    for (int i = 0; i < 4; i++)
      sb.push_back('{adr: exp_adr[i], cti: (i == 3) ? 3'b111 : 3'b010, we: 1'b0, dat: exp_adr[i] ^ PAT});
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_adr_a = 32'h1E;
    #1;
    checks++;
    if (cyc_a !== 1'b0) begin errors++; $display("FAIL wrap_latency: cyc got %b want 0 in request cycle", cyc_a); end
    @(negedge clk);
    req_valid_a = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      #1;
      if (rd_valid_a) n_rd++;
      if (cyc_a && stb_a && ack_a) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL wrap_extra_beat: adr %h want no beat", adr_a);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({adr_a, cti_a, bte_a} !== {e.adr, e.cti, 2'b01})
            begin errors++; $display("FAIL wrap_beat: got %h/%b/%b want %h/%b/01", adr_a, cti_a, bte_a, e.adr, e.cti); end
          checks++;
          if ({rd_valid_a, rd_dat_a} !== {1'b1, e.dat})
            begin errors++; $display("FAIL wrap_rdata: got %b/%h want 1/%h", rd_valid_a, rd_dat_a, e.dat); end
        end
      end
      if (done_a) begin
        fin = 1'b1;
        checks++;
        if ({err_o_a, cyc_a} !== 2'b00) begin errors++; $display("FAIL wrap_done: err/cyc got %b want 00", {err_o_a, cyc_a}); end
      end
      @(negedge clk);
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL wrap_timeout: done got 0 want 1 within 20 cycles"); end
    checks++;
    if (n_rd != 4 || sb.size() != 0) begin errors++; $display("FAIL wrap_count: rd_valid %0d left %0d want 4/0", n_rd, sb.size()); end
  endtask

  task automatic test_linear_write;
    beat_t e;
    int k = 0, st2 = 0, st5 = 0, n_wr = 0, n_done = 0, n_stall = 0;
    bit stall, fin = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++)
      sb.push_back('{adr: 32'h100 + 32'(4 * i), cti: (i == 7) ? 3'b111 : 3'b010, we: 1'b1, dat: 32'hA000_0000 + 32'(i)});
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = 1'b1; req_adr_b = 32'h100; wr_valid_b = 1'b0;
    @(negedge clk);
    req_valid_b = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      stall = (k == 2 && st2 < 2) || (k == 5 && st5 < 2);
      wr_valid_b = !stall;
      wr_dat_b   = 32'hA000_0000 + 32'(k);
      #1;
      if (wr_ready_b) n_wr++;
      if (stall) begin
        if (k == 2) st2++; else st5++;
        n_stall++;
        checks++;
        if ({stb_b, cyc_b, adr_b, cti_b} !== {2'b01, 32'h100 + 32'(4 * k), 3'b010})
          begin errors++; $display("FAIL write_wait: stb/cyc/adr/cti got %b%b/%h/%b want 01/%h/010", stb_b, cyc_b, adr_b, cti_b, 32'h100 + 32'(4 * k)); end
      end
      if (stb_b && ack_b) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL write_extra_beat: adr %h want no beat", adr_b);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({adr_b, cti_b, bte_b, we_b, dat_o_b, wr_ready_b} !== {e.adr, e.cti, 2'b00, 1'b1, e.dat, 1'b1})
            begin errors++; $display("FAIL write_beat: got %h/%b/%b/%b/%h/%b want %h/%b/00/1/%h/1", adr_b, cti_b, bte_b, we_b, dat_o_b, wr_ready_b, e.adr, e.cti, e.dat); end
        end
        k++;
      end
      if (done_b) begin n_done++; fin = 1'b1; end
      @(negedge clk);
    end
    wr_valid_b = 1'b0;
    repeat (3) begin
      #1;
      if (done_b) n_done++;
      @(negedge clk);
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL write_timeout: done got 0 want 1 within 40 cycles"); end
    checks++;
    if (n_wr != 8 || n_done != 1 || n_stall != 4 || sb.size() != 0)
      begin errors++; $display("FAIL write_count: wr_ready %0d done %0d stalls %0d left %0d want 8/1/4/0", n_wr, n_done, n_stall, sb.size()); end
  endtask

  task automatic test_err_abort;
    beat_t e;
    int k = 0, n_rd = 0, err_c = -1, done_c = -1;
    bit fin = 1'b0;
    sb.delete();
    sb.push_back('{adr: 32'h0, cti: 3'b010, we: 1'b0, dat: 32'h0 ^ PAT});
    sb.push_back('{adr: 32'h4, cti: 3'b010, we: 1'b0, dat: 32'h4 ^ PAT});
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_adr_a = 32'h0;
    @(negedge clk);
    req_valid_a = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      err_now_a = (k == 2);
      #1;
      if (rd_valid_a) n_rd++;
      if (stb_a && ack_a) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL err_extra_beat: adr %h want none", adr_a);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({adr_a, cti_a, rd_valid_a, rd_dat_a} !== {e.adr, e.cti, 1'b1, e.dat})
            begin errors++; $display("FAIL err_beat: got %h/%b/%b/%h want %h/%b/1/%h", adr_a, cti_a, rd_valid_a, rd_dat_a, e.adr, e.cti, e.dat); end
        end
        k++;
      end
      if (err_a) begin
        err_c = c;
        checks++;
        if ({cyc_a, rd_valid_a, done_a, adr_a} !== {3'b100, 32'h8})
          begin errors++; $display("FAIL err_cycle: cyc/rd_valid/done/adr got %b%b%b/%h want 100/00000008", cyc_a, rd_valid_a, done_a, adr_a); end
      end
      if (done_a) begin
        done_c = c;
        fin = 1'b1;
        checks++;
        if ({err_o_a, cyc_a} !== 2'b10) begin errors++; $display("FAIL err_done: err/cyc got %b want 10", {err_o_a, cyc_a}); end
      end
      @(negedge clk);
    end
    err_now_a = 1'b0;
    checks++;
    if (!fin || err_c < 0 || done_c != err_c + 1)
      begin errors++; $display("FAIL err_timing: err cycle %0d done cycle %0d want done one cycle after err", err_c, done_c); end
    checks++;
    if (n_rd != 2) begin errors++; $display("FAIL err_rd_count: got %0d want 2", n_rd); end
  endtask

  task automatic test_reset_mid;
    beat_t e;
    int n_done = 0, n_rd = 0;
    bit fin = 1'b0;
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_adr_a = 32'h20;
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({cyc_a, adr_a, cti_a} !== {1'b1, 32'h24, 3'b010})
      begin errors++; $display("FAIL rstmid_beat1: cyc/adr/cti got %b/%h/%b want 1/00000024/010", cyc_a, adr_a, cti_a); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cyc_a, stb_a, cti_a, bte_a, req_ready_a, done_a, err_o_a} !== 10'b00_000_00_100)
      begin errors++; $display("FAIL rstmid_after: cyc stb cti bte ready done err got %b want 0000000100", {cyc_a, stb_a, cti_a, bte_a, req_ready_a, done_a, err_o_a}); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (done_a) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL rstmid_no_done: done pulses %0d want 0", n_done); end
    sb.delete();
    for (int i = 0; i < 4; i++)
      sb.push_back('{adr: 32'h30 + 32'(4 * i), cti: (i == 3) ? 3'b111 : 3'b010, we: 1'b0, dat: (32'h30 + 32'(4 * i)) ^ PAT});
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_adr_a = 32'h30;
    @(negedge clk);
    req_valid_a = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      #1;
      if (rd_valid_a) n_rd++;
      if (stb_a && ack_a && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({adr_a, cti_a, rd_dat_a} !== {e.adr, e.cti, e.dat})
          begin errors++; $display("FAIL rstmid_beat: got %h/%b/%h want %h/%b/%h", adr_a, cti_a, rd_dat_a, e.adr, e.cti, e.dat); end
      end
      if (done_a) begin
        fin = 1'b1;
        checks++;
        if (err_o_a !== 1'b0) begin errors++; $display("FAIL rstmid_done_err: got %b want 0", err_o_a); end
      end
      @(negedge clk);
    end
    checks++;
    if (!fin || n_rd != 4 || sb.size() != 0)
      begin errors++; $display("FAIL rstmid_recover: done %b rd_valid %0d left %0d want 1/4/0", fin, n_rd, sb.size()); end
  endtask

  task automatic test_back_to_back;
    beat_t e;
    int n_acc = 0, phase = 0, gap = 0;
    bit fin = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++)
      sb.push_back('{adr: 32'h40 + 32'(4 * i), cti: (i == 3) ? 3'b111 : 3'b010, we: 1'b0, dat: (32'h40 + 32'(4 * i)) ^ PAT});
    for (int i = 0; i < 4; i++)
      sb.push_back('{adr: 32'h80 + 32'(4 * i), cti: (i == 3) ? 3'b111 : 3'b010, we: 1'b1, dat: 32'h5000_0000 + 32'(i)});
    @(negedge clk);
    for (int c = 0; c < 40 && !fin; c++) begin
      if (n_acc == 0)      begin req_valid_a = 1'b1; req_we_a = 1'b0; req_adr_a = 32'h40; end
      else if (n_acc == 1) begin req_valid_a = 1'b1; req_we_a = 1'b1; req_adr_a = 32'h80; end
      else                 req_valid_a = 1'b0;
      wr_valid_a = 1'b1;
      wr_dat_a   = (sb.size() != 0) ? sb[0].dat : 32'h0;
      #1;
      if (req_valid_a && req_ready_a) begin
        if (n_acc == 1) begin
          checks++;
          if ({done_a, cyc_a} !== 2'b10) begin errors++; $display("FAIL b2b_accept: done/cyc got %b want 10", {done_a, cyc_a}); end
        end
        n_acc++;
      end
      if (cyc_a) begin
        if (phase == 0) phase = 1; else if (phase == 2) phase = 3;
      end else begin
        if (phase == 1) phase = 2;
        if (phase == 2) gap++;
      end
      if (stb_a && ack_a) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra_beat: adr %h want none", adr_a);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({adr_a, cti_a, we_a} !== {e.adr, e.cti, e.we})
            begin errors++; $display("FAIL b2b_beat: got %h/%b/%b want %h/%b/%b", adr_a, cti_a, we_a, e.adr, e.cti, e.we); end
          checks++;
          if (e.we ? ({dat_o_a, wr_ready_a, rd_valid_a} !== {e.dat, 2'b10}) : ({rd_dat_a, rd_valid_a, wr_ready_a} !== {e.dat, 2'b10}))
            begin errors++; $display("FAIL b2b_data: got wdat %h rdat %h wr_ready %b rd_valid %b want %h", dat_o_a, rd_dat_a, wr_ready_a, rd_valid_a, e.dat); end
        end
      end
      if (done_a && phase == 3) fin = 1'b1;
      @(negedge clk);
    end
    wr_valid_a  = 1'b0;
    req_valid_a = 1'b0;
    checks++;
    if (!fin || n_acc != 2 || sb.size() != 0)
      begin errors++; $display("FAIL b2b_complete: done %b accepts %0d left %0d want 1/2/0", fin, n_acc, sb.size()); end
    checks++;
    if (gap != 1) begin errors++; $display("FAIL b2b_gap: idle cycles %0d want 1", gap); end
  endtask

  task automatic test_timeout;
    int n_hi = 0, n_done = 0;
    bit fin = 1'b0;
    hang_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b1; req_we_a = 1'b0; req_adr_a = 32'h0;
    @(negedge clk);
    req_valid_a = 1'b0;
`ifdef WB_BURST_TIMEOUT_EN
    for (int c = 0; c < 50 && !fin; c++) begin
      #1;
      if (stb_a) n_hi++;
      if (done_a) begin
        fin = 1'b1;
        checks++;
        if ({err_o_a, cyc_a} !== 2'b10) begin errors++; $display("FAIL tmo_done: err/cyc got %b want 10", {err_o_a, cyc_a}); end
      end
      @(negedge clk);
    end
    checks++;
    if (!fin || n_hi != 8) begin errors++; $display("FAIL tmo_count: done %b stb cycles %0d want 1/8", fin, n_hi); end
`else
    for (int c = 0; c < 100; c++) begin
      #1;
      if (cyc_a && stb_a) n_hi++;
      if (done_a) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_hi != 100 || n_done != 0) begin errors++; $display("FAIL hang_hold: cyc cycles %0d done %0d want 100/0", n_hi, n_done); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cyc_a, done_a, req_ready_a} !== 3'b001) begin errors++; $display("FAIL hang_reset: cyc/done/ready got %b want 001", {cyc_a, done_a, req_ready_a}); end
    @(negedge clk);
`endif
    hang_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid_a = 1'b0; req_we_a = 1'b0; req_adr_a = '0; wr_dat_a = '0; wr_valid_a = 1'b0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_adr_b = '0; wr_dat_b = '0; wr_valid_b = 1'b0;
    hang_a = 1'b0; err_now_a = 1'b0;
    test_reset;
    test_wrap_read;
    test_linear_write;
    test_err_abort;
    test_reset_mid;
    test_back_to_back;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
